// File: rtl/pix_stream_pkg.sv
// Shared types and default geometry for the pixel frame streamer.
package pix_stream_pkg;

  localparam int WIDTH_DEF       = 120;
  localparam int HEIGHT_DEF      = 52;
  localparam int WORD_W_DEF      = 8;
  localparam int WORDS_PER_ROW   = WIDTH_DEF / WORD_W_DEF;
  localparam int WORDS_PER_FRAME = HEIGHT_DEF * WORDS_PER_ROW;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Counter width that stays >= 1 even for a single-entry range.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_word_mux.sv
// Pure combinational word picker: returns WORD_W pixels of the frame
// buffer starting at pixel row*WIDTH + w*WORD_W.
module pix_word_mux #(
  parameter int WIDTH  = 120,
  parameter int HEIGHT = 52,
  parameter int WORD_W = 8,
  parameter int ROW_W  = 6,
  parameter int WI_W   = 4
) (
  input  logic [WIDTH*HEIGHT-1:0] i_buf,
  input  logic [ROW_W-1:0]        i_row,
  input  logic [WI_W-1:0]         i_w,
  output logic [WORD_W-1:0]       o_word
);

  localparam int IDX_W = $clog2(WIDTH*HEIGHT) + 1;

  logic [IDX_W-1:0] w_base;

  assign w_base = IDX_W'(i_row) * IDX_W'(WIDTH) + IDX_W'(i_w) * IDX_W'(WORD_W);
  assign o_word = i_buf[w_base +: WORD_W];

endmodule

// File: rtl/pix_frame_streamer.sv
// Captures a whole evaluated frame and streams it out row by row as
// WORD_W-pixel words with sof/eol/eof framing flags.
module pix_frame_streamer
  import pix_stream_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [WIDTH*HEIGHT-1:0] frame_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic [15:0]             frame_cnt
);

  localparam int WPR   = WIDTH / WORD_W;
  localparam int ROW_W = cw(HEIGHT);
  localparam int WI_W  = cw(WPR);

  state_e                  r_state;
  logic                    r_valid;
  logic [ROW_W-1:0]        r_row;
  logic [WI_W-1:0]         r_w;
  logic [15:0]             r_frame_cnt;
  logic [WIDTH*HEIGHT-1:0] r_buf;

  logic              w_capture;
  logic              w_fire;
  logic              w_eol;
  logic              w_last_row;
  logic [WORD_W-1:0] w_word;

  assign w_capture  = (r_state == IDLE) && frame_valid;
  assign w_fire     = r_valid && out_ready;
  assign w_eol      = (r_w == WI_W'(WPR - 1));
  assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));

  // Frame buffer: loaded only on capture, frozen while streaming.
  always_ff @(posedge clk) begin
    if (w_capture) r_buf <= frame_pix;
  end

  // Control FSM: capture, word/row walk, frame completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_row       <= '0;
      r_w         <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_valid) begin
            r_row   <= '0;
            r_w     <= '0;
            r_valid <= 1'b1;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_fire) begin
            if (w_eol) begin
              r_w <= '0;
              if (w_last_row) begin
                // eof handshake: frame done, upstream may re-capture next cycle
                r_row       <= '0;
                r_valid     <= 1'b0;
                r_state     <= IDLE;
                r_frame_cnt <= r_frame_cnt + 16'd1;
              end else begin
                r_row <= r_row + ROW_W'(1);
              end
            end else begin
              r_w <= r_w + WI_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  pix_word_mux #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .WORD_W (WORD_W),
    .ROW_W  (ROW_W),
    .WI_W   (WI_W)
  ) u_mux (
    .i_buf  (r_buf),
    .i_row  (r_row),
    .i_w    (r_w),
    .o_word (w_word)
  );

  // Outputs decode from registered indices; gating by r_valid keeps them
  // at zero during and right after reset, whatever the buffer holds.
  assign frame_ready = (r_state == IDLE);
  assign out_valid   = r_valid;
  assign out_data    = r_valid ? w_word : '0;
  assign out_sof     = r_valid && (r_row == '0) && (r_w == '0);
  assign out_eol     = r_valid && w_eol;
  assign out_eof     = r_valid && w_eol && w_last_row;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_pix_frame_streamer.sv
// Scoreboard bench: stimulus pushes expected words per captured frame,
// a negedge monitor pops and compares on every output handshake.
module tb_pix_frame_streamer;

  localparam int W   = 120;
  localparam int H   = 52;
  localparam int WW  = 8;
  localparam int WPR = W / WW;
  localparam int WPF = H * WPR;
  localparam int PIX = W * H;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_valid = 1'b0;
  logic           frame_ready;
  logic [PIX-1:0] frame_pix = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [WW-1:0]  out_data;
  logic           out_sof, out_eol, out_eof;
  logic [15:0]    frame_cnt;

  pix_frame_streamer #(.WIDTH(W), .HEIGHT(H), .WORD_W(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_pix   (frame_pix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .out_eof     (out_eof),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          widx = 0;
  int          eof_cyc = -10;
  int          cap_cyc = 0;
  bit          rand_ready = 1'b0;
  bit          stalled = 1'b0;
  exp_t        held;
  logic [WW-1:0] seen_d[WPF];
  logic [2:0]    seen_f[WPF];
  logic [15:0]   exp_cnt = '0;
  logic [PIX-1:0] f1, f2, f3a, f3b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sink: always ready unless random back-pressure is enabled.
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pop/compare on handshake, check hold during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stalled)
        chk("stall_hold", {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, held});
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
          end else begin
            e = q.pop_front();
            chk($sformatf("word%0d", widx), {out_data, out_sof, out_eol, out_eof}, e);
          end
          if (widx < WPF) begin
            seen_d[widx] = out_data;
            seen_f[widx] = {out_sof, out_eol, out_eof};
          end
          if (out_eof) begin
            widx    = 0;
            eof_cyc = cyc;
          end else begin
            widx++;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {out_data, out_sof, out_eol, out_eof};
        end
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
      widx    = 0;
    end
  end

  task automatic push_frame(input logic [PIX-1:0] p);
    exp_t e;
    int row, w, base;
    for (int k = 0; k < WPF; k++) begin
      row   = k / WPR;
      w     = k % WPR;
      base  = row * W + w * WW;
      e.d   = p[base +: WW];
      e.sof = (k == 0);
      e.eol = (w == WPR - 1);
      e.eof = (k == WPF - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [PIX-1:0] p, input bit hold, input logic [PIX-1:0] nxt);
    int n = 0;
    @(negedge clk);
    frame_pix   = p;
    frame_valid = 1'b1;
    while (!frame_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_ready) begin
      chk("capture_timeout", 32'(n), 32'(0));
      frame_valid = 1'b0;
    end else begin
      cap_cyc = cyc;
      push_frame(p);
      @(posedge clk);
      #1;
      frame_pix = nxt;
      if (!hold) frame_valid = 1'b0;
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'(1));
      chk("latency_sof", 32'(out_sof), 32'(1));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(frame_ready && !out_valid) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(frame_ready && !out_valid), 32'(1));
    chk("queue_drained", 32'(q.size()), 32'(0));
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int n;
    f1 = '0;  f1[7:0] = 8'hA5;
    f2 = '0;  f2[119] = 1'b1;
    f3a = f1; f3a[PIX-1 -: 8] = 8'h5A;
    f3b = '0; f3b[15:8] = 8'hC3; f3b[127:120] = 8'h11;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_flags", 32'({out_sof, out_eol, out_eof}), 32'(0));
    chk("rst_cnt", 32'(frame_cnt), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(frame_ready), 32'(1));

    // Basic frame: A5 in first word
    send_frame(f1, 1'b0, f1);
    exp_cnt = 16'd1;
    wait_idle();
    chk("f1_w0", 32'(seen_d[0]), 32'(8'hA5));
    chk("f1_w0_flags", 32'(seen_f[0]), 32'(3'b100));
    chk("f1_w1", 32'(seen_d[1]), 32'(0));
    chk("f1_w779_flags", 32'(seen_f[WPF-1]), 32'(3'b011));

    // Last pixel of row 0 lands in word 14, bit 7
    send_frame(f2, 1'b0, f2);
    exp_cnt = 16'd2;
    wait_idle();
    chk("f2_w14", 32'(seen_d[14]), 32'(8'h80));
    chk("f2_w14_flags", 32'(seen_f[14]), 32'(3'b010));
    chk("f2_w15", 32'(seen_d[15]), 32'(0));
    chk("f2_w15_flags", 32'(seen_f[15]), 32'(3'b000));

    // Random back-pressure
    rand_ready = 1'b1;
    send_frame(f1, 1'b0, f1);
    exp_cnt = 16'd3;
    wait_idle();
    rand_ready = 1'b0;

    // frame_valid held: mid-stream frame_pix change must not leak
    send_frame(f3a, 1'b1, f3b);
    send_frame(f3b, 1'b0, f3b);
    chk("bubble_cycles", 32'(cap_cyc - eof_cyc), 32'(1));
    exp_cnt = 16'd5;
    wait_idle();

    // Reset in the middle of a frame
    send_frame(f1, 1'b0, f1);
    n = 0;
    while (widx < 300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_word300", 32'(widx >= 300), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_cnt", 32'(frame_cnt), 32'(0));
    chk("midrst_data", 32'(out_data), 32'(0));
    chk("midrst_flags", 32'({out_sof, out_eol, out_eof}), 32'(0));
    q.delete();
    widx = 0;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(f1, 1'b0, f1);
    exp_cnt = 16'd1;
    wait_idle();

    // Frame counter wrap
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    chk("cnt_forced", 32'(frame_cnt), 32'(16'hFFFF));
    send_frame(f2, 1'b0, f2);
    exp_cnt = 16'h0000;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
